// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : ID/EX pipeline register for the execute-stage ALU. Resolves
//             rs/rt through EX/MEM and MEM/WB forwarding, extends the 16-bit
//             immediate by ALU function, detects load-use hazards, stalls
//             decode, and counts stall cycles. Registered outputs sit behind
//             a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REGBITS-1:0] rs_addr,
  input  logic [REGBITS-1:0] rt_addr,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [15:0]        imm16,
  input  logic               is_imm,
  input  logic [3:0]         af_in,
  input  logic [REGBITS-1:0] dst_in,
  input  logic               exm_wen,
  input  logic [REGBITS-1:0] exm_addr,
  input  logic [WIDTH-1:0]   exm_data,
  input  logic               exm_is_load,
  input  logic               mwb_wen,
  input  logic [REGBITS-1:0] mwb_addr,
  input  logic [WIDTH-1:0]   mwb_data,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   SrcA,
  output logic [WIDTH-1:0]   SrcB,
  output logic [3:0]         af,
  output logic               i,
  output logic [REGBITS-1:0] dst,
  output logic [15:0]        stall_cnt
);

  localparam logic [15:0]        C_CNT_MAX = 16'hFFFF;
  localparam logic [REGBITS-1:0] C_R0      = '0;

  // Pipeline state
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   srca_q, srca_d;
  logic [WIDTH-1:0]   srcb_q, srcb_d;
  logic [3:0]         af_q, af_d;
  logic               i_q, i_d;
  logic [REGBITS-1:0] dst_q, dst_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic [WIDTH-1:0]   w_rs_val;
  logic [WIDTH-1:0]   w_rt_val;
  logic [WIDTH-1:0]   w_imm_ext;
  logic               w_hazard;
  logic               w_advance;

  // Register 0 reads as zero; the younger EX/MEM result beats MEM/WB.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [REGBITS-1:0] addr,
    input logic [WIDTH-1:0]   rf_val,
    input logic               e_wen,
    input logic [REGBITS-1:0] e_addr,
    input logic [WIDTH-1:0]   e_data,
    input logic               m_wen,
    input logic [REGBITS-1:0] m_addr,
    input logic [WIDTH-1:0]   m_data
  );
    logic [WIDTH-1:0] r;
    if (addr == C_R0)                      r = '0;
    else if (e_wen && (e_addr == addr))    r = e_data;
    else if (m_wen && (m_addr == addr))    r = m_data;
    else                                   r = rf_val;
    return r;
  endfunction

  // Operand forwarding, immediate extension and hazard/handshake decode
  always_comb begin
    w_rs_val = resolve(rs_addr, rs_data, exm_wen, exm_addr, exm_data,
                       mwb_wen, mwb_addr, mwb_data);
    w_rt_val = resolve(rt_addr, rt_data, exm_wen, exm_addr, exm_data,
                       mwb_wen, mwb_addr, mwb_data);
    // Arithmetic forms (af 00xx) sign-extend; logical, lui and 1xxx zero-extend.
    if (af_in[3:2] == 2'b00) w_imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};
    else                     w_imm_ext = {{(WIDTH-16){1'b0}}, imm16};
    // A load in EX/MEM has no data yet, so a dependent read must wait.
    w_hazard  = in_valid && exm_wen && exm_is_load && (exm_addr != C_R0) &&
                ((exm_addr == rs_addr) || (!is_imm && (exm_addr == rt_addr)));
    w_advance = out_ready || !out_valid_q;
    if (reset)      in_ready = 1'b0;
    else if (flush) in_ready = 1'b1;
    else            in_ready = w_advance && !w_hazard;
  end

  // Next-state: flush beats accept, accept beats bubble, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    af_d        = af_q;
    i_d         = i_q;
    dst_d       = dst_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_advance && in_valid && !w_hazard) begin
      out_valid_d = 1'b1;
      srca_d      = w_rs_val;
      srcb_d      = is_imm ? w_imm_ext : w_rt_val;
      af_d        = af_in;
      i_d         = is_imm;
      dst_d       = dst_in;
    end else if (w_advance) begin
      out_valid_d = 1'b0;
    end
    if (w_hazard && !flush && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      srca_q      <= '0;
      srcb_q      <= '0;
      af_q        <= '0;
      i_q         <= 1'b0;
      dst_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      af_q        <= af_d;
      i_q         <= i_d;
      dst_q       <= dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign SrcA      = srca_q;
  assign SrcB      = srcb_q;
  assign af        = af_q;
  assign i         = i_q;
  assign dst       = dst_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Self-checking bench for alu_operand_stage: directed scenarios
//             followed by random traffic, all compared against a behavioural
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, is_imm, exm_wen, exm_is_load;
  logic        mwb_wen, flush, out_ready, out_valid, i_o;
  logic [4:0]  rs_addr, rt_addr, dst_in, exm_addr, mwb_addr, dst_o;
  logic [31:0] rs_data, rt_data, exm_data, mwb_data, src_a, src_b;
  logic [15:0] imm16, stall_cnt;
  logic [3:0]  af_in, af_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_af;
  logic        m_i;
  logic [4:0]  m_dst;
  logic [15:0] m_cnt;
  logic        ready_seen;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .is_imm(is_imm), .af_in(af_in), .dst_in(dst_in),
    .exm_wen(exm_wen), .exm_addr(exm_addr), .exm_data(exm_data),
    .exm_is_load(exm_is_load), .mwb_wen(mwb_wen), .mwb_addr(mwb_addr),
    .mwb_data(mwb_data), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .SrcA(src_a), .SrcB(src_b), .af(af_o), .i(i_o),
    .dst(dst_o), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (exm_wen && exm_addr == a) return exm_data;
    if (mwb_wen && mwb_addr == a) return mwb_data;
    return rf;
  endfunction

  function automatic logic [31:0] immediate(input logic [3:0] f, input logic [15:0] v);
    int s;
    if (f < 4) begin
      s = $signed(v);
      return s;
    end
    return {16'd0, v};
  endfunction

  task automatic idle();
    reset = 0; in_valid = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
    imm16 = 0; is_imm = 0; af_in = 0; dst_in = 0; exm_wen = 0; exm_addr = 0;
    exm_data = 0; exm_is_load = 0; mwb_wen = 0; mwb_addr = 0; mwb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge
  task automatic tick(input string tag);
    bit haz, adv, exp_rdy;
    logic [31:0] na, nb;
    #2;
    haz = in_valid && exm_wen && exm_is_load && exm_addr != 0 &&
          (exm_addr == rs_addr || (!is_imm && exm_addr == rt_addr));
    adv = out_ready || !m_valid;
    exp_rdy = reset ? 1'b0 : (flush ? 1'b1 : (adv && !haz));
    ready_seen = in_ready;
    chk(tag, "in_ready", in_ready, exp_rdy);
    na = operand(rs_addr, rs_data);
    nb = is_imm ? immediate(af_in, imm16) : operand(rt_addr, rt_data);
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_a = 0; m_b = 0; m_af = 0; m_i = 0; m_dst = 0; m_cnt = 0;
    end else begin
      if (haz && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (flush) m_valid = 0;
      else if (adv && in_valid && !haz) begin
        m_valid = 1; m_a = na; m_b = nb; m_af = af_in; m_i = is_imm; m_dst = dst_in;
      end else if (adv) m_valid = 0;
    end
    #1;
    chk(tag, "out_valid", out_valid, m_valid);
    chk(tag, "SrcA", src_a, m_a);
    chk(tag, "SrcB", src_b, m_b);
    chk(tag, "af", af_o, m_af);
    chk(tag, "i", i_o, m_i);
    chk(tag, "dst", dst_o, m_dst);
    chk(tag, "stall_cnt", stall_cnt, m_cnt);
  endtask

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_af = 0; m_i = 0; m_dst = 0; m_cnt = 0;
    ready_seen = 0;
    idle();
    reset = 1;
    #1;
    tick("reset0");
    tick("reset1");
    chk("reset", "in_ready_c", ready_seen, 0);
    chk("reset", "out_valid_c", out_valid, 0);
    chk("reset", "stall_cnt_c", stall_cnt, 0);

    // addi r3 + 20
    idle(); in_valid = 1; rs_addr = 3; rs_data = 10; imm16 = 16'h0014;
    is_imm = 1; af_in = 4'b0000; dst_in = 7;
    tick("addi");
    chk("addi", "SrcA_c", src_a, 10);
    chk("addi", "SrcB_c", src_b, 20);
    chk("addi", "valid_c", out_valid, 1);
    chk("addi", "i_c", i_o, 1);

    af_in = 4'b0010; imm16 = 16'hFFF6;
    tick("slti");
    chk("slti", "SrcB_c", src_b, 32'hFFFF_FFF6);
    af_in = 4'b0101;
    tick("ori");
    chk("ori", "SrcB_c", src_b, 32'h0000_FFF6);
    af_in = 4'b0111; imm16 = 16'hFFFF;
    tick("lui");
    chk("lui", "SrcB_c", src_b, 32'h0000_FFFF);

    // forwarding priority
    idle(); in_valid = 1; rs_addr = 5; rt_addr = 5; rs_data = 1; rt_data = 1;
    exm_wen = 1; exm_addr = 5; exm_data = 7; mwb_wen = 1; mwb_addr = 5; mwb_data = 9;
    af_in = 4'b1000;
    tick("fwd");
    chk("fwd", "SrcA_c", src_a, 7);
    chk("fwd", "SrcB_c", src_b, 7);

    idle(); in_valid = 1; rs_addr = 0; rs_data = 123; exm_wen = 1; exm_addr = 0;
    exm_data = 32'hDEAD;
    tick("r0");
    chk("r0", "SrcA_c", src_a, 0);

    // load-use hazard for two cycles, then release
    idle(); in_valid = 1; rs_addr = 4; rs_data = 3; exm_wen = 1; exm_addr = 4;
    exm_is_load = 1; exm_data = 32'h99;
    tick("haz1");
    chk("haz1", "in_ready_c", ready_seen, 0);
    tick("haz2");
    chk("haz2", "in_ready_c", ready_seen, 0);
    chk("haz2", "valid_c", out_valid, 0);
    chk("haz2", "stall_c", stall_cnt, 2);
    exm_is_load = 0; exm_data = 32'h55;
    tick("haz_rel");
    chk("haz_rel", "SrcA_c", src_a, 32'h55);
    chk("haz_rel", "stall_c", stall_cnt, 2);

    // downstream stall for three cycles, then flush
    idle(); in_valid = 1; rs_addr = 6; rs_data = 32'h77;
    tick("ds_load");
    out_ready = 0; rs_data = 32'h88; dst_in = 9;
    for (int k = 0; k < 3; k++) begin
      tick("ds_hold");
      chk("ds_hold", "in_ready_c", ready_seen, 0);
      chk("ds_hold", "SrcA_c", src_a, 32'h77);
    end
    flush = 1;
    tick("ds_flush");
    chk("ds_flush", "valid_c", out_valid, 0);
    chk("ds_flush", "SrcA_c", src_a, 32'h77);

    // hazard together with flush: no stall counted
    idle(); in_valid = 1; rs_addr = 2; exm_wen = 1; exm_addr = 2; exm_is_load = 1;
    flush = 1;
    tick("haz_flush");
    chk("haz_flush", "stall_c", stall_cnt, 2);
    flush = 0;
    tick("haz3");
    reset = 1;
    tick("haz_reset");
    chk("haz_reset", "stall_c", stall_cnt, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      reset       = ($urandom_range(0, 63) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      rs_addr     = 5'($urandom_range(0, 7));
      rt_addr     = 5'($urandom_range(0, 7));
      rs_data     = $urandom;
      rt_data     = $urandom;
      imm16       = 16'($urandom);
      is_imm      = $urandom_range(0, 1) == 1;
      af_in       = 4'($urandom);
      dst_in      = 5'($urandom);
      exm_wen     = $urandom_range(0, 1) == 1;
      exm_addr    = 5'($urandom_range(0, 7));
      exm_data    = $urandom;
      exm_is_load = ($urandom_range(0, 2) == 0);
      mwb_wen     = $urandom_range(0, 1) == 1;
      mwb_addr    = 5'($urandom_range(0, 7));
      mwb_data    = $urandom;
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
